// File: rtl/player_anim_ctrl_if.sv
// Shared direction type and the movement-to-animation handshake bundle.
// Master is the movement side, slave is the animation sequencer.
package player_anim_pkg;
    typedef enum logic [2:0] {
        DIR_DOWN  = 3'd0,
        DIR_LEFT  = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_UP    = 3'd3
    } dir_t;
endpackage

interface player_anim_if;
    import player_anim_pkg::*;

    logic       frame_tick;
    logic       moving;
    dir_t       move_dir;
    dir_t       dir;
    logic [1:0] walk_frame;
    logic       walking;
    logic       anim_changed;

    modport master (
        output frame_tick,
        output moving,
        output move_dir,
        input  dir,
        input  walk_frame,
        input  walking,
        input  anim_changed
    );

    modport slave (
        input  frame_tick,
        input  moving,
        input  move_dir,
        output dir,
        output walk_frame,
        output walking,
        output anim_changed
    );
endinterface

// File: rtl/player_anim_ctrl.sv
// Per-player walk-cycle sequencer; all state advances only on frame_tick
// so the sprite drawer sees a stable (dir, walk_frame) across a frame.
module player_anim_ctrl
    import player_anim_pkg::*;
#(
    parameter int FRAME_TICKS         = 8,
    parameter int WALK_FRAMES_PER_DIR = 3
) (
    input  logic           clk,
    input  logic           rst,
    player_anim_if.slave   bus
);

    localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

    if (WALK_FRAMES_PER_DIR != 3) begin : g_bad_frames
        $error("player_anim_ctrl: WALK_FRAMES_PER_DIR must be 3");
    end
    if (FRAME_TICKS < 1 || FRAME_TICKS > 255) begin : g_bad_ticks
        $error("player_anim_ctrl: FRAME_TICKS must be 1..255");
    end

    typedef enum logic {
        IDLE,
        WALK
    } state_t;

    state_t        state, state_nxt;
    dir_t          dir_q, dir_nxt;
    logic [1:0]    wf_q, wf_nxt;
    logic [1:0]    phase_q, phase_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          chg_q, chg_nxt;
    logic [1:0]    phase_inc;
    logic          legal;
    logic          turn;

    // Walk cycle by phase: 1, 0, 2, 0 (frame 0 is the standing pose).
    function automatic logic [1:0] seq_frame(input logic [1:0] p);
        return p[0] ? 2'd0 : (p[1] ? 2'd2 : 2'd1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dir_q   <= DIR_DOWN;
            wf_q    <= 2'd0;
            phase_q <= 2'd0;
            cnt_q   <= '0;
            chg_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            dir_q   <= dir_nxt;
            wf_q    <= wf_nxt;
            phase_q <= phase_nxt;
            cnt_q   <= cnt_nxt;
            chg_q   <= chg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_q;
        wf_nxt    = wf_q;
        phase_nxt = phase_q;
        cnt_nxt   = cnt_q;
        chg_nxt   = 1'b0;
        phase_inc = phase_q + 2'd1;
        legal     = bus.move_dir inside {DIR_DOWN, DIR_LEFT, DIR_RIGHT, DIR_UP};
        // Illegal encodings never cause a turn; they read as "same dir".
        turn      = legal && (bus.move_dir != dir_q);

        if (bus.frame_tick) begin
            unique case (state)
                IDLE: begin
                    if (bus.moving) begin
                        state_nxt = WALK;
                        if (legal) dir_nxt = bus.move_dir;
                        phase_nxt = 2'd0;
                        wf_nxt    = 2'd1;
                        cnt_nxt   = '0;
                    end else begin
                        wf_nxt = 2'd0;
                    end
                end
                WALK: begin
                    if (!bus.moving) begin
                        state_nxt = IDLE;
                        wf_nxt    = 2'd0;
                        phase_nxt = 2'd0;
                        cnt_nxt   = '0;
                    end else if (turn) begin
                        dir_nxt   = bus.move_dir;
                        phase_nxt = 2'd0;
                        wf_nxt    = 2'd1;
                        cnt_nxt   = '0;
                    end else if (cnt_q == LAST) begin
                        cnt_nxt   = '0;
                        phase_nxt = phase_inc;
                        wf_nxt    = seq_frame(phase_inc);
                    end else begin
                        cnt_nxt = cnt_q + CW'(1);
                    end
                end
            endcase
            chg_nxt = (dir_nxt != dir_q) || (wf_nxt != wf_q);
        end
    end

    assign bus.dir          = dir_q;
    assign bus.walk_frame   = wf_q;
    assign bus.walking      = (state == WALK);
    assign bus.anim_changed = chg_q;

endmodule

// File: tb/tb_player_anim_ctrl.sv
// Bench for player_anim_ctrl: vector table, walk-wrap sequence and
// randomized traffic against an elapsed-tick reference model.
module tb_player_anim_ctrl;
    import player_anim_pkg::*;

    logic clk;
    logic rst;

    player_anim_if a_if ();
    player_anim_if b_if ();

    player_anim_ctrl #(.FRAME_TICKS(2)) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(a_if.slave)
    );

    player_anim_ctrl #(.FRAME_TICKS(1)) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       t;
        logic       mv;
        logic [2:0] md;
        logic [2:0] d;
        logic [1:0] wf;
        logic       wk;
        logic       ch;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   passed;

    int          ft[2];
    int          seq[4];
    logic        m_walk[2];
    logic [2:0]  m_dir[2];
    int          m_n[2];
    logic [1:0]  m_wf[2];
    logic        m_chg[2];

    function automatic void add(input logic r, t, mv, input logic [2:0] md,
                                input logic [2:0] d, input logic [1:0] wf,
                                input logic wk, ch);
        vec_t v;
        v.r = r; v.t = t; v.mv = mv; v.md = md;
        v.d = d; v.wf = wf; v.wk = wk; v.ch = ch;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp, $time);
    endtask

    // Reference: frame is derived from ticks elapsed since walk start/turn.
    task automatic model_update(input logic r, t, mv, input logic [2:0] md);
        logic [4:0] old;
        logic       legal;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_walk[k] = 1'b0;
                m_dir[k]  = 3'd0;
                m_n[k]    = 0;
                m_wf[k]   = 2'd0;
                m_chg[k]  = 1'b0;
            end else if (t) begin
                old   = {m_dir[k], m_wf[k]};
                legal = (md < 3'd4);
                if (!mv) begin
                    m_walk[k] = 1'b0;
                    m_n[k]    = 0;
                    m_wf[k]   = 2'd0;
                end else begin
                    if (!m_walk[k] || (legal && md != m_dir[k])) begin
                        if (legal) m_dir[k] = md;
                        m_walk[k] = 1'b1;
                        m_n[k]    = 0;
                    end else begin
                        m_n[k]++;
                    end
                    m_wf[k] = 2'(seq[(m_n[k] / ft[k]) % 4]);
                end
                m_chg[k] = ({m_dir[k], m_wf[k]} != old);
            end else begin
                m_chg[k] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, t, mv, input logic [2:0] md);
        @(negedge clk);
        rst             = r;
        a_if.frame_tick = t;
        a_if.moving     = mv;
        a_if.move_dir   = dir_t'(md);
        b_if.frame_tick = t;
        b_if.moving     = mv;
        b_if.move_dir   = dir_t'(md);
        @(posedge clk);
        model_update(r, t, mv, md);
        #1;
    endtask

    task automatic cmp_models();
        chk("a_dir", int'(a_if.dir), int'(m_dir[0]));
        chk("a_wf", int'(a_if.walk_frame), int'(m_wf[0]));
        chk("a_walk", int'(a_if.walking), int'(m_walk[0]));
        chk("a_chg", int'(a_if.anim_changed), int'(m_chg[0]));
        chk("b_dir", int'(b_if.dir), int'(m_dir[1]));
        chk("b_wf", int'(b_if.walk_frame), int'(m_wf[1]));
        chk("b_walk", int'(b_if.walking), int'(m_walk[1]));
        chk("b_chg", int'(b_if.anim_changed), int'(m_chg[1]));
    endtask

    initial begin
        int wf_exp[10];
        int ch_exp[10];
        int ft1[8];
        logic       r, t, mv;
        logic [2:0] md;

        total = 0;
        passed = 0;
        ft  = '{2, 1};
        seq = '{1, 0, 2, 0};
        rst = 1'b1;
        a_if.frame_tick = 1'b0; a_if.moving = 1'b0; a_if.move_dir = DIR_DOWN;
        b_if.frame_tick = 1'b0; b_if.moving = 1'b0; b_if.move_dir = DIR_DOWN;

        // Table for the FRAME_TICKS=2 instance.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 0, 0, 0);
        wf_exp = '{1, 1, 0, 0, 2, 2, 0, 0, 1, 1};
        ch_exp = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
        for (int i = 0; i < 10; i++)
            add(0, 1, 1, 2, 2, 2'(wf_exp[i]), 1, ch_exp[i][0]);
        add(0, 1, 1, 2, 2, 0, 1, 1);
        add(0, 1, 1, 2, 2, 0, 1, 0);
        add(0, 1, 1, 2, 2, 2, 1, 1);
        add(0, 1, 1, 2, 2, 2, 1, 0);
        // Turn at phase 2: restart at frame 1, next change two ticks on.
        add(0, 1, 1, 3, 3, 1, 1, 1);
        add(0, 1, 1, 3, 3, 1, 1, 0);
        add(0, 1, 1, 3, 3, 0, 1, 1);
        // Input churn without a tick is ignored.
        add(0, 0, 0, 1, 3, 0, 1, 0);
        add(0, 0, 1, 0, 3, 0, 1, 0);
        add(0, 0, 0, 2, 3, 0, 1, 0);
        // Reset beats a coincident tick.
        add(1, 1, 1, 2, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 1, 1, 1);
        add(0, 1, 1, 1, 1, 1, 1, 0);
        add(0, 1, 1, 1, 1, 0, 1, 1);
        add(0, 1, 1, 1, 1, 0, 1, 0);
        add(0, 1, 1, 1, 1, 2, 1, 1);
        add(0, 1, 0, 1, 1, 0, 0, 1);
        add(0, 1, 1, 1, 1, 1, 1, 1);
        // Illegal move_dir counts as the current direction.
        add(0, 1, 1, 5, 1, 1, 1, 0);
        add(0, 1, 1, 7, 1, 0, 1, 1);

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].t, vecs[i].mv, vecs[i].md);
            chk($sformatf("v%0d_dir", i), int'(a_if.dir), int'(vecs[i].d));
            chk($sformatf("v%0d_wf", i), int'(a_if.walk_frame), int'(vecs[i].wf));
            chk($sformatf("v%0d_walk", i), int'(a_if.walking), int'(vecs[i].wk));
            chk($sformatf("v%0d_chg", i), int'(a_if.anim_changed), int'(vecs[i].ch));
        end

        // FRAME_TICKS=1: phase advances every tick and wraps 3 -> 0.
        step(1, 0, 0, 0);
        ft1 = '{1, 0, 2, 0, 1, 0, 2, 0};
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 0);
            chk($sformatf("ft1_wf%0d", i), int'(b_if.walk_frame), ft1[i]);
        end
        step(0, 0, 1, 0);
        chk("ft1_chg_idle", int'(b_if.anim_changed), 0);

        // Randomized traffic against the model for both instances.
        step(1, 0, 0, 0);
        cmp_models();
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            t  = ($urandom_range(0, 2) == 0);
            mv = ($urandom_range(0, 3) != 0);
            md = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7))
               : ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 3))
               : m_dir[0];
            step(r, t, mv, md);
            cmp_models();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/player_anim_ctrl.md
# player_anim_ctrl

Per-player animation sequencer that drives the `dir` and `walk_frame` inputs of the player sprite draw controller. It consumes the movement intent from player motion logic and a once-per-video-frame tick. It produces a frame-stable facing direction and walk-cycle frame index, so the sprite drawer never changes frame mid-scan. One instance per player sits between the movement FSM and its sprite draw controller.

## Interface
- `FRAME_TICKS`, default 8: number of `frame_tick` pulses each walk-cycle step is held; legal range 1..255.
- `WALK_FRAMES_PER_DIR`, default 3: frames per direction in the sprite ROM. Fixed at 3; elaboration error otherwise.
- `clk` input 1: system/pixel clock. One clock.
- `rst` input 1: reset, synchronous, active-high.
- `frame_tick` input 1: single-cycle pulse once per video frame, asserted during blanking.
- `moving` input 1: player is currently being displaced this frame.
- `move_dir` input `dir_t`: requested direction (DIR_DOWN/LEFT/RIGHT/UP); sampled only when `moving`=1.
- `dir` output `dir_t`: facing direction to sprite drawer.
- `walk_frame` output 2: frame index within direction, 0..2.
- `walking` output 1: high while FSM is in WALK.
- `anim_changed` output 1: one-cycle pulse when `dir` or `walk_frame` changed value.

## Operation
- State: FSM {IDLE, WALK}; `tick_cnt` (`$clog2(FRAME_TICKS)`, minimum 1 bit); `phase` (2 bits); registered `dir`, `walk_frame`.
- Walk sequence by phase: 0→frame 1, 1→frame 0, 2→frame 2, 3→frame 0. Frame 0 is the standing pose.
- All state updates occur only on cycles with `frame_tick`=1. On all other cycles every register holds.
- IDLE, tick with `moving`=0: hold `dir`; `walk_frame`=0.
- IDLE, tick with `moving`=1: go to WALK. Set `dir`←`move_dir`, `phase`←0, `walk_frame`←1, `tick_cnt`←0.
- WALK, tick with `moving`=0: go to IDLE. Set `walk_frame`←0, `phase`←0, `tick_cnt`←0, and hold `dir`.
- WALK, tick with `moving`=1 and `move_dir`≠`dir`: turn. Set `dir`←`move_dir`, restart `phase`←0, `walk_frame`←1, `tick_cnt`←0. Stay in WALK.
- WALK, tick with `moving`=1 and same dir:
  - If `tick_cnt`=FRAME_TICKS−1: set `tick_cnt`←0, `phase`←`phase`+1 (mod 4, wraps 3→0), `walk_frame`←seq[new phase].
  - Otherwise: `tick_cnt`←`tick_cnt`+1.
- `move_dir` value outside the four legal encodings while `moving`=1 is treated as equal to current `dir` (no turn).
- `anim_changed` is asserted the cycle after the tick iff the new (`dir`, `walk_frame`) differs from the previous value. Turning to a new dir always pulses it.
- `walking` = (state == WALK).
- `FRAME_TICKS`=1: phase advances every tick while walking straight.

## Timing
- Reset (`rst`=1 at a clock edge): state IDLE, `dir`=DIR_DOWN, `walk_frame`=0, `phase`=0, `tick_cnt`=0, `walking`=0, `anim_changed`=0.
- `rst` has priority over a coincident `frame_tick`. The tick is lost.
- Latency: inputs sampled at the edge where `frame_tick`=1; outputs valid the following cycle (1-cycle registered).
- Outputs are constant between ticks, so the drawer sees a stable pair for the entire active display.
- `moving`/`move_dir` changes between ticks are ignored; only the value at the tick edge matters.
- Back-to-back ticks (on consecutive cycles) are legal; each is processed independently.
- Reset mid-walk returns to IDLE/DIR_DOWN/frame 0 with no `anim_changed` pulse on the reset cycle.

## Test plan
- Reset, then 5 ticks with `moving`=0 → `dir`=DIR_DOWN, `walk_frame`=0, `walking`=0, `anim_changed` never asserted.
- `FRAME_TICKS`=2, `moving`=1, `move_dir`=DIR_RIGHT for 10 ticks → `walk_frame` after each tick: 1,1,0,0,2,2,0,0,1,1. `anim_changed` pulses after ticks 1,3,5,7,9.
- Walking DIR_RIGHT at phase 2, tick with `move_dir`=DIR_UP → next cycle `dir`=DIR_UP, `walk_frame`=1, `anim_changed`=1; `tick_cnt` restarted, so the next change comes FRAME_TICKS ticks later.
- Walking DIR_LEFT at `walk_frame`=2, tick with `moving`=0 → `walk_frame`=0, `dir`=DIR_LEFT, `walking`=0. Following tick with `moving`=1 restarts at `walk_frame`=1.
- Toggle `moving` and `move_dir` many times between ticks with `frame_tick`=0 → outputs unchanged. Assert `rst` together with `frame_tick` while walking → reset values next cycle, tick ignored.
- `FRAME_TICKS`=1, `moving`=1 constant, 8 ticks → `walk_frame` sequence 1,0,2,0,1,0,2,0 (phase wrap 3→0 verified).
